wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 131 +++++++++++++
 tb/tb_wb_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Write-back queue: merges ALU and load-unit results into a DEPTH-entry FIFO,
// drains one entry per cycle into a registered register-file write port, and
// offers a combinational forwarding lookup over the queued (not yet written)
// entries. Writes to address 0 are discarded and counted.
module wb_queue #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] fwd_address,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [7:0]        drop_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ROOM2 = CNT_W'(DEPTH - 2);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, mem_slot, fwd_idx;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [7:0]        drop_q, drop_d;
  logic              alu_fire, mem_fire, pop;

  // Acceptance is decided from the registered count only; the same-cycle pop
  // never frees a slot. The MEM port yields the last slot to the ALU port.
  always_comb begin
    alu_ready = (count_q < CNT_FULL);
    mem_ready = (count_q <= CNT_ROOM2) || ((count_q == CNT_LAST) && !alu_valid);
    alu_fire  = alu_valid && alu_ready;
    mem_fire  = mem_valid && mem_ready;
  end

  // Pointer/count bookkeeping and write-port next state; ALU entry lands
  // ahead of the MEM entry when both are accepted in one cycle.
  always_comb begin
    pop      = (count_q != '0);
    mem_slot = alu_fire ? tail_q + PTR_W'(1) : tail_q;
    tail_d   = tail_q + PTR_W'(alu_fire) + PTR_W'(mem_fire);
    head_d   = pop ? head_q + PTR_W'(1) : head_q;
    count_d  = count_q + CNT_W'(alu_fire) + CNT_W'(mem_fire) - CNT_W'(pop);
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    drop_d   = drop_q;
    if (pop) begin
      wa_d = addr_q[head_q];
      wd_d = data_q[head_q];
      if (addr_q[head_q] != '0) begin
        we_d = 1'b1;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  // Control and write-port registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      drop_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      drop_q  <= drop_d;
    end
  end

  // Entry storage; validity is tracked by head/count so no reset is needed.
  always_ff @(posedge clk) begin
    if (alu_fire) begin
      addr_q[tail_q] <= alu_addr;
      data_q[tail_q] <= alu_data;
    end
    if (mem_fire) begin
      addr_q[mem_slot] <= mem_addr;
      data_q[mem_slot] <= mem_data;
    end
  end

  // Forwarding: scan oldest to newest so the newest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (fwd_address != '0) &&
          (addr_q[fwd_idx] == fwd_address)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign write_enable  = we_q;
  assign write_address = wa_q;
  assign write_data    = wd_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (default DEPTH=4 instance plus a
// DEPTH=2 instance used to reach the full condition).
module tb_wb_queue;

  logic       clk, rst;
  logic       alu_valid, mem_valid;
  logic [4:0] alu_addr, mem_addr, fwd_address;
  logic [7:0] alu_data, mem_data;
  logic       alu_ready, mem_ready, write_enable, fwd_hit;
  logic [4:0] write_address;
  logic [7:0] write_data, fwd_data, drop_count;

  logic       b_alu_valid, b_mem_valid;
  logic [4:0] b_alu_addr, b_mem_addr, b_fwd_address;
  logic [7:0] b_alu_data, b_mem_data;
  logic       b_alu_ready, b_mem_ready, b_write_enable, b_fwd_hit;
  logic [4:0] b_write_address;
  logic [7:0] b_write_data, b_fwd_data, b_drop_count;

  int n_chk  = 0;
  int n_fail = 0;

  wb_queue #(.ADDR_W(5), .DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .fwd_address(fwd_address), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .drop_count(drop_count)
  );

  wb_queue #(.ADDR_W(5), .DATA_W(8), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .alu_valid(b_alu_valid), .alu_ready(b_alu_ready), .alu_addr(b_alu_addr), .alu_data(b_alu_data),
    .mem_valid(b_mem_valid), .mem_ready(b_mem_ready), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
    .write_enable(b_write_enable), .write_address(b_write_address), .write_data(b_write_data),
    .fwd_address(b_fwd_address), .fwd_hit(b_fwd_hit), .fwd_data(b_fwd_data),
    .drop_count(b_drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] wa, input logic [7:0] wd);
    chk({tag, "_we"}, write_enable, we);
    if (we) begin
      chk({tag, "_wa"}, write_address, wa);
      chk({tag, "_wd"}, write_data, wd);
    end
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 0; alu_addr = '0; alu_data = '0;
    mem_valid = 0; mem_addr = '0; mem_data = '0;
    fwd_address = 5'd3;
    b_alu_valid = 0; b_alu_addr = '0; b_alu_data = '0;
    b_mem_valid = 0; b_mem_addr = '0; b_mem_data = '0;
    b_fwd_address = '0;

    // Reset state
    step(); step();
    chk("rst_we", write_enable, 0);
    chk("rst_wa", write_address, 0);
    chk("rst_wd", write_data, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_alu_rdy", alu_ready, 1);
    chk("rst_mem_rdy", mem_ready, 1);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
    rst = 1'b1;
    step();

    // Single ALU write: latency and one-cycle strobe
    alu_valid = 1; alu_addr = 5'd3; alu_data = 8'h5A;
    #1 chk("single_fwd_empty", fwd_hit, 0);
    step();
    alu_valid = 0; alu_data = 8'h77;
    chk("single_fwd_hit", fwd_hit, 1);
    chk("single_fwd_data", fwd_data, 8'h5A);
    chk("single_we_early", write_enable, 0);
    step();
    chk_wr("single_out", 1, 5'd3, 8'h5A);
    chk("single_fwd_after_pop", fwd_hit, 0);
    step();
    chk("single_we_off", write_enable, 0);
    chk("single_wa_hold", write_address, 5'd3);
    chk("single_wd_hold", write_data, 8'h5A);

    // Dual issue: newest entry forwards, ALU drains first
    alu_valid = 1; alu_addr = 5'd1; alu_data = 8'h11;
    mem_valid = 1; mem_addr = 5'd1; mem_data = 8'h22;
    #1 chk("dual_alu_rdy", alu_ready, 1);
    chk("dual_mem_rdy", mem_ready, 1);
    step();
    alu_valid = 0; mem_valid = 0;
    fwd_address = 5'd1;
    #1 chk("dual_fwd_hit", fwd_hit, 1);
    chk("dual_fwd_data", fwd_data, 8'h22);
    step(); chk_wr("dual_out0", 1, 5'd1, 8'h11);
    step(); chk_wr("dual_out1", 1, 5'd1, 8'h22);
    step(); chk("dual_idle", write_enable, 0);

    // Fill to DEPTH-1, then the last-slot arbitration
    alu_valid = 1; alu_addr = 5'd4; alu_data = 8'hA1;
    mem_valid = 1; mem_addr = 5'd5; mem_data = 8'hB1;
    step();                                     // count 2
    alu_addr = 5'd6; alu_data = 8'hA2;
    mem_addr = 5'd7; mem_data = 8'hB2;
    #1 chk("fill_c2_alu_rdy", alu_ready, 1);
    chk("fill_c2_mem_rdy", mem_ready, 1);
    step();                                     // count 3, A1 written
    chk_wr("fill_out_a1", 1, 5'd4, 8'hA1);
    alu_addr = 5'd8; alu_data = 8'hA3;
    mem_addr = 5'd9; mem_data = 8'hB3;
    fwd_address = 5'd7;
    #1 chk("last_alu_rdy", alu_ready, 1);
    chk("last_mem_rdy", mem_ready, 0);
    chk("last_fwd_b2", fwd_data, 8'hB2);
    step();                                     // A3 in, B3 refused, B1 out
    chk_wr("fill_out_b1", 1, 5'd5, 8'hB1);
    alu_valid = 0; mem_valid = 0;
    fwd_address = 5'd9;
    #1 chk("last_mem_rdy_noalu", mem_ready, 1);
    chk("refused_b3_fwd", fwd_hit, 0);
    step(); chk_wr("fill_out_a2", 1, 5'd6, 8'hA2);
    step(); chk_wr("fill_out_b2", 1, 5'd7, 8'hB2);
    step(); chk_wr("fill_out_a3", 1, 5'd8, 8'hA3);
    step(); chk("fill_idle", write_enable, 0);

    // Address-0 drop
    alu_valid = 1; alu_addr = 5'd0; alu_data = 8'hFF;
    step();
    alu_valid = 0;
    fwd_address = 5'd0;
    #1 chk("drop_fwd_hit", fwd_hit, 0);
    chk("drop_fwd_data", fwd_data, 0);
    step();
    chk("drop_we", write_enable, 0);
    chk("drop_cnt1", drop_count, 1);
    step();
    chk("drop_cnt_stable", drop_count, 1);

    // Wrap-around: 3*DEPTH back-to-back ALU writes drain in order
    for (int i = 0; i < 12; i++) begin
      alu_valid = 1; alu_addr = 5'(i + 1); alu_data = 8'(8'h30 + i);
      step();
      if (i > 0) chk_wr($sformatf("wrap_%0d", i - 1), 1, 5'(i), 8'(8'h30 + i - 1));
    end
    alu_valid = 0;
    step(); chk_wr("wrap_11", 1, 5'd12, 8'h3B);
    step(); chk("wrap_idle", write_enable, 0);

    // drop_count saturates at 255 (1 already counted)
    alu_valid = 1; alu_addr = 5'd0; alu_data = 8'h01;
    for (int i = 0; i < 300; i++) step();
    alu_valid = 0;
    step(); step();
    chk("drop_sat", drop_count, 8'd255);
    chk("drop_sat_we", write_enable, 0);

    // DEPTH=2 instance: reach the full condition
    b_alu_valid = 1; b_alu_addr = 5'd2; b_alu_data = 8'hC1;
    b_mem_valid = 1; b_mem_addr = 5'd3; b_mem_data = 8'hC2;
    step();
    b_alu_valid = 0; b_mem_valid = 0;
    b_fwd_address = 5'd3;
    #1 chk("full_alu_rdy", b_alu_ready, 0);
    chk("full_mem_rdy", b_mem_ready, 0);
    chk("full_fwd", b_fwd_data, 8'hC2);
    step();
    chk("full_out_we", b_write_enable, 1);
    chk("full_out_wa", b_write_address, 5'd2);
    chk("full_out_wd", b_write_data, 8'hC1);
    chk("full_drain_alu_rdy", b_alu_ready, 1);
    step();
    chk("full_out2_wd", b_write_data, 8'hC2);

    // Reset mid-operation with 3 entries queued
    step();
    alu_valid = 1; alu_addr = 5'd10; alu_data = 8'hD1;
    mem_valid = 1; mem_addr = 5'd11; mem_data = 8'hD2;
    step();
    alu_addr = 5'd12; alu_data = 8'hD3;
    mem_addr = 5'd13; mem_data = 8'hD4;
    step();                                     // count 3
    alu_valid = 0; mem_valid = 0;
    fwd_address = 5'd13;
    #1 chk("pre_rst_fwd", fwd_hit, 1);
    rst = 1'b0;
    #1 chk("mid_rst_we", write_enable, 0);
    chk("mid_rst_fwd", fwd_hit, 0);
    chk("mid_rst_alu_rdy", alu_ready, 1);
    chk("mid_rst_mem_rdy", mem_ready, 1);
    chk("mid_rst_drop", drop_count, 0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("post_rst_we_%0d", i), write_enable, 0);
    end
    chk("post_rst_fwd", fwd_hit, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
